// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg
//   Shared definitions for the MIPS execute unit: ALU control encodings,
//   multiply/divide operation codes and the mul/div sequencer state type.
//   No ports; imported by mips_alu_md and mips_muldiv_seq.
package mips_alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SRA  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_XOR  = 4'b1101;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic {
    MD_IDLE,
    MD_RUN
  } md_state_t;

endpackage

// File: rtl/mips_muldiv_seq.sv
// mips_muldiv_seq
//   Iterative radix-2 multiply / restoring divide engine with HI/LO registers.
//   One step per clock for WIDTH clocks after a start is accepted in IDLE.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   op_a, op_b          operands (rs, rt), latched when a start is accepted
//   md_op               MULT / MULTU / DIV / DIVU
//   md_start            start request, honoured only in IDLE
//   md_busy             engine running
//   md_done             one-cycle pulse when hi/lo have been written
//   md_div_by_zero      qualifies md_done: the divisor was zero
//   hi, lo              result registers
module mips_muldiv_seq
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       md_op,
  input  logic             md_start,
  output logic             md_busy,
  output logic             md_done,
  output logic             md_div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t state, state_next;

  logic [SHW-1:0]   count;
  logic             is_div_r, a_neg_r, b_neg_r;
  logic [WIDTH-1:0] a_orig_r, b_mag_r;
  logic [WIDTH-1:0] p_hi, p_lo;

  logic             signed_op;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             last_step;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_mag, prod_fin;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem, div_quo;
  logic [WIDTH-1:0]   step_hi, step_lo, fin_hi, fin_lo;
  logic               b_zero;

  always_ff @(posedge clk) begin
    if (reset) state <= MD_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (md_start)        state_next = MD_RUN;
      MD_RUN:  if (count == '0)     state_next = MD_IDLE;
      default:                      state_next = MD_IDLE;
    endcase
  end

  always_comb begin
    md_busy   = (state == MD_RUN);
    last_step = (state == MD_RUN) && (count == '0);
  end

  // Signed ops run on magnitudes; signs are reapplied on the final step.
  always_comb begin
    signed_op = (md_op == MD_MULT) || (md_op == MD_DIV);
    a_mag     = (signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
    b_mag     = (signed_op && op_b[WIDTH-1]) ? -op_b : op_b;
  end

  // p_lo holds the multiplier (shifted out LSB first) or the dividend
  // (shifted out MSB first while quotient bits shift in); p_hi holds the
  // upper partial product or the running remainder.
  always_comb begin
    mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, b_mag_r} : {(WIDTH+1){1'b0}});
    prod_mag  = {mul_sum, p_lo[WIDTH-1:1]};
    div_shift = {p_hi, p_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_mag_r};
    div_ge    = ~div_diff[WIDTH];
    div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_quo   = {p_lo[WIDTH-2:0], div_ge};
    step_hi   = is_div_r ? div_rem : prod_mag[2*WIDTH-1:WIDTH];
    step_lo   = is_div_r ? div_quo : prod_mag[WIDTH-1:0];
  end

  // Result fix-up: quotient takes the XOR of the signs, remainder follows
  // the dividend. A zero divisor overrides with all-ones / dividend.
  always_comb begin
    b_zero   = (b_mag_r == '0);
    prod_fin = (a_neg_r ^ b_neg_r) ? -prod_mag : prod_mag;
    fin_hi   = prod_fin[2*WIDTH-1:WIDTH];
    fin_lo   = prod_fin[WIDTH-1:0];
    if (is_div_r) begin
      if (b_zero) begin
        fin_hi = a_orig_r;
        fin_lo = '1;
      end else begin
        fin_hi = a_neg_r ? -div_rem : div_rem;
        fin_lo = (a_neg_r ^ b_neg_r) ? -div_quo : div_quo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count          <= '0;
      is_div_r       <= 1'b0;
      a_neg_r        <= 1'b0;
      b_neg_r        <= 1'b0;
      a_orig_r       <= '0;
      b_mag_r        <= '0;
      p_hi           <= '0;
      p_lo           <= '0;
      hi             <= '0;
      lo             <= '0;
      md_done        <= 1'b0;
      md_div_by_zero <= 1'b0;
    end else begin
      md_done        <= 1'b0;
      md_div_by_zero <= 1'b0;
      if (state == MD_IDLE) begin
        if (md_start) begin
          count    <= SHW'(WIDTH - 1);
          is_div_r <= md_op[1];
          a_neg_r  <= signed_op & op_a[WIDTH-1];
          b_neg_r  <= signed_op & op_b[WIDTH-1];
          a_orig_r <= op_a;
          b_mag_r  <= b_mag;
          p_hi     <= '0;
          p_lo     <= a_mag;
        end
      end else begin
        count <= count - SHW'(1);
        p_hi  <= step_hi;
        p_lo  <= step_lo;
        if (last_step) begin
          hi             <= fin_hi;
          lo             <= fin_lo;
          md_done        <= 1'b1;
          md_div_by_zero <= is_div_r & b_zero;
        end
      end
    end
  end

endmodule

// File: rtl/mips_alu_md.sv
// mips_alu_md
//   MIPS EX-stage unit: combinational ALU with zero/overflow flags plus an
//   iterative multiply/divide engine writing HI/LO.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   read_data_1                operand A (rs)
//   alu_src_output             operand B (rt or immediate)
//   shamt                      shift amount for SLL/SRL/SRA (shifts B)
//   alu_ctrl                   ALU operation select
//   alu_result, zero, overflow combinational ALU result and flags
//   md_start, md_op            mul/div request
//   md_busy, md_done           engine status
//   md_div_by_zero             qualifies md_done for zero divisors
//   hi, lo                     mul/div result registers
module mips_alu_md
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] read_data_1,
  input  logic [WIDTH-1:0] alu_src_output,
  input  logic [SHW-1:0]   shamt,
  input  logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             overflow,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  output logic             md_busy,
  output logic             md_done,
  output logic             md_div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] a, b, sum, diff;
  logic             a_s, b_s;

  always_comb begin
    a    = read_data_1;
    b    = alu_src_output;
    sum  = a + b;
    diff = a - b;
    a_s  = a[WIDTH-1];
    b_s  = b[WIDTH-1];
  end

  always_comb begin
    alu_result = '0;
    overflow   = 1'b0;
    case (alu_ctrl)
      ALU_AND:  alu_result = a & b;
      ALU_OR:   alu_result = a | b;
      ALU_ADD: begin
        alu_result = sum;
        overflow   = (a_s == b_s) && (sum[WIDTH-1] != a_s);
      end
      ALU_SUB: begin
        alu_result = diff;
        overflow   = (a_s != b_s) && (diff[WIDTH-1] != a_s);
      end
      ALU_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_NOR:  alu_result = ~(a | b);
      ALU_XOR:  alu_result = a ^ b;
      ALU_SLL:  alu_result = b << shamt;
      ALU_SRL:  alu_result = b >> shamt;
      ALU_SRA:  alu_result = $signed(b) >>> shamt;
      default:  alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  mips_muldiv_seq #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_muldiv (
    .clk            (clk),
    .reset          (reset),
    .op_a           (read_data_1),
    .op_b           (alu_src_output),
    .md_op          (md_op),
    .md_start       (md_start),
    .md_busy        (md_busy),
    .md_done        (md_done),
    .md_div_by_zero (md_div_by_zero),
    .hi             (hi),
    .lo             (lo)
  );

endmodule

// File: tb/tb_mips_alu_md.sv
// tb_mips_alu_md
//   Directed-vector bench for mips_alu_md: ALU ops and flags, then mul/div
//   results, latency, back-to-back starts, ignored starts and reset abort.
module tb_mips_alu_md;

  logic        clk;
  logic        reset;
  logic [31:0] read_data_1;
  logic [31:0] alu_src_output;
  logic [4:0]  shamt;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        zero;
  logic        overflow;
  logic        md_start;
  logic [1:0]  md_op;
  logic        md_busy;
  logic        md_done;
  logic        md_div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int compare_count;
  int mismatch_count;

  mips_alu_md #(.WIDTH(32), .SHW(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .read_data_1    (read_data_1),
    .alu_src_output (alu_src_output),
    .shamt          (shamt),
    .alu_ctrl       (alu_ctrl),
    .alu_result     (alu_result),
    .zero           (zero),
    .overflow       (overflow),
    .md_start       (md_start),
    .md_op          (md_op),
    .md_busy        (md_busy),
    .md_done        (md_done),
    .md_div_by_zero (md_div_by_zero),
    .hi             (hi),
    .lo             (lo)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives the ALU inputs and lets the combinational result settle.
  task automatic applyStimulus(input logic [3:0] ctrl, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] sh);
    alu_ctrl       = ctrl;
    read_data_1    = a;
    alu_src_output = b;
    shamt          = sh;
    #1;
  endtask

  task automatic aluCase(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh,
                         input logic [31:0] exp_res, input logic exp_zero,
                         input logic exp_ovf);
    applyStimulus(ctrl, a, b, sh);
    checkOutput({tag, "_result"}, {32'd0, alu_result}, {32'd0, exp_res});
    checkOutput({tag, "_zero"}, {63'd0, zero}, {63'd0, exp_zero});
    checkOutput({tag, "_ovf"}, {63'd0, overflow}, {63'd0, exp_ovf});
  endtask

  // Issues a start (called just after a rising edge), then counts edges
  // until md_done. A second start is injected before edge glitch_at when
  // glitch_at > 0; it must be ignored while busy. Bounded to 40 edges.
  task automatic runMd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int glitch_at, output int done_edge, output bit busy_ok);
    md_op          = op;
    read_data_1    = a;
    alu_src_output = b;
    md_start       = 1'b1;
    @(posedge clk); #1;
    md_start  = 1'b0;
    busy_ok   = md_busy;
    done_edge = 0;
    for (int n = 1; n <= 40 && done_edge == 0; n++) begin
      if (n == glitch_at) begin
        md_start       = 1'b1;
        md_op          = 2'b11;
        read_data_1    = 32'd99;
        alu_src_output = 32'd0;
      end
      @(posedge clk); #1;
      md_start = 1'b0;
      if (md_done) done_edge = n;
      else if (!md_busy) busy_ok = 1'b0;
    end
  endtask

  task automatic mdCase(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int glitch_at,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dbz);
    int done_edge;
    bit busy_ok;
    runMd(op, a, b, glitch_at, done_edge, busy_ok);
    checkOutput({tag, "_latency"}, 64'(done_edge), 64'd32);
    checkOutput({tag, "_busy_run"}, {63'd0, busy_ok}, 64'd1);
    checkOutput({tag, "_busy_done"}, {63'd0, md_busy}, 64'd0);
    checkOutput({tag, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
    checkOutput({tag, "_dbz"}, {63'd0, md_div_by_zero}, {63'd0, exp_dbz});
  endtask

  initial begin
    int edges_done;
    compare_count  = 0;
    mismatch_count = 0;
    reset          = 1'b1;
    md_start       = 1'b0;
    md_op          = 2'b00;
    applyStimulus(4'b0000, 32'd0, 32'd0, 5'd0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hilo", {hi, lo}, 64'd0);
    checkOutput("reset_flags", {61'd0, md_busy, md_done, md_div_by_zero}, 64'd0);
    reset = 1'b0;

    aluCase("add",      4'b0010, 32'd50,        32'd20,        5'd0,  32'd70,        1'b0, 1'b0);
    aluCase("sub_zero", 4'b0110, 32'd50,        32'd50,        5'd0,  32'd0,         1'b1, 1'b0);
    aluCase("unknown",  4'b1111, 32'h1234_5678, 32'h0000_0001, 5'd3,  32'd0,         1'b1, 1'b0);
    aluCase("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b0, 1'b1);
    aluCase("sub_ovf",  4'b0110, 32'h8000_0000, 32'h0000_0001, 5'd0,  32'h7FFF_FFFF, 1'b0, 1'b1);
    aluCase("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'd0,         1'b1, 1'b0);
    aluCase("and_noov", 4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0, 1'b0);
    aluCase("slt",      4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'd1,         1'b0, 1'b0);
    aluCase("sltu",     4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'd0,         1'b1, 1'b0);
    aluCase("sra",      4'b0101, 32'd0,         32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 1'b0);
    aluCase("srl",      4'b0100, 32'd0,         32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, 1'b0);
    aluCase("sll",      4'b0011, 32'd0,         32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0);
    aluCase("nor",      4'b1100, 32'd0,         32'd0,         5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0);
    aluCase("or",       4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 5'd0,  32'h0000_FFF0, 1'b0, 1'b0);
    aluCase("xor",      4'b1101, 32'h0000_F0F0, 32'h0000_FF00, 5'd0,  32'h0000_0FF0, 1'b0, 1'b0);

    @(posedge clk); #1;
    mdCase("mult",     2'b00, 32'hFFFF_FFFD, 32'd7,         0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hilo_hold", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    mdCase("multu",    2'b01, 32'hFFFF_FFFF, 32'd2,         0, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    // Started in the md_done cycle of the previous operation.
    mdCase("div_b2b",  2'b10, 32'hFFFF_FFF9, 32'd2,         0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    mdCase("divu_dbz", 2'b11, 32'd7,         32'd0,         0, 32'd7,         32'hFFFF_FFFF, 1'b1);
    mdCase("div_min",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0,         32'h8000_0000, 1'b0);
    mdCase("div_negb", 2'b10, 32'd7,         32'hFFFF_FFFE, 0, 32'd1,         32'hFFFF_FFFD, 1'b0);
    mdCase("divu",     2'b11, 32'd100,       32'd7,         0, 32'd2,         32'd14,        1'b0);
    mdCase("ign_start",2'b01, 32'd3,         32'd5,         5, 32'd0,         32'd15,        1'b0);
    @(posedge clk); #1;
    checkOutput("done_pulse", {63'd0, md_done}, 64'd0);

    // Make hi/lo nonzero, then abort a MULT 10 edges in.
    mdCase("pre_abort",2'b01, 32'd6,         32'd7,         0, 32'd0,         32'd42,        1'b0);
    md_op          = 2'b00;
    read_data_1    = 32'd9;
    alu_src_output = 32'd9;
    md_start       = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("abort_busy_before", {63'd0, md_busy}, 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abort_busy", {63'd0, md_busy}, 64'd0);
    checkOutput("abort_hilo", {hi, lo}, 64'd0);
    edges_done = 0;
    for (int n = 0; n < 35; n++) begin
      @(posedge clk); #1;
      if (md_done || md_busy) edges_done++;
    end
    checkOutput("abort_no_done", 64'(edges_done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
